// File: rtl/multi_pkg.sv
// multi_pkg: shared encodings for the multi-cycle MIPS control path.
//   - state codes (FETCH=0 .. TRAP=12, JAL=13) and the matching state enum
//   - opcode constants (IR[31:26])
//   - datapath select codes: ALU_OP_*, SRCB_*, PCSRC_*, REGDST_*, M2R_*
// The optional JAL instruction is enabled by defining MULTI_JAL_EN.
package multi_pkg;

   // State codes; also visible on the debug 'state' port.
   localparam logic [3:0] FETCH     = 4'd0;
   localparam logic [3:0] DECODE    = 4'd1;
   localparam logic [3:0] MEM_ADDR  = 4'd2;
   localparam logic [3:0] MEM_READ  = 4'd3;
   localparam logic [3:0] MEM_WB    = 4'd4;
   localparam logic [3:0] MEM_WRITE = 4'd5;
   localparam logic [3:0] R_EXEC    = 4'd6;
   localparam logic [3:0] R_WB      = 4'd7;
   localparam logic [3:0] BRANCH    = 4'd8;
   localparam logic [3:0] JUMP      = 4'd9;
   localparam logic [3:0] I_EXEC    = 4'd10;
   localparam logic [3:0] I_WB      = 4'd11;
   localparam logic [3:0] TRAP      = 4'd12;
   localparam logic [3:0] JAL       = 4'd13;

   typedef enum logic [3:0] {
      StFetch    = FETCH,
      StDecode   = DECODE,
      StMemAddr  = MEM_ADDR,
      StMemRead  = MEM_READ,
      StMemWb    = MEM_WB,
      StMemWrite = MEM_WRITE,
      StRExec    = R_EXEC,
      StRWb      = R_WB,
      StBranch   = BRANCH,
      StJump     = JUMP,
      StIExec    = I_EXEC,
      StIWb      = I_WB,
      StTrap     = TRAP,
      StJal      = JAL
   } state_e;

   // Opcodes
   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_JAL  = 6'h03;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_BNE  = 6'h05;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;

   // ALU operation
   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

   // ALU operand A / memory address source
   localparam logic SRCA_PC     = 1'b0;
   localparam logic SRCA_A      = 1'b1;
   localparam logic IORD_PC     = 1'b0;
   localparam logic IORD_ALUOUT = 1'b1;

   // ALU operand B
   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   // PC source
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Register file write address / data
   localparam logic [1:0] REGDST_RT  = 2'b00;
   localparam logic [1:0] REGDST_RD  = 2'b01;
   localparam logic [1:0] REGDST_RA  = 2'b10;
   localparam logic [1:0] M2R_ALUOUT = 2'b00;
   localparam logic [1:0] M2R_MDR    = 2'b01;
   localparam logic [1:0] M2R_PC     = 2'b10;

   // States that wait on the memory handshake and are covered by the watchdog.
   function automatic logic is_mem_wait(state_e s);
      return (s == StFetch) || (s == StMemRead) || (s == StMemWrite);
   endfunction

endpackage

// File: rtl/multi_wdog.sv
// multi_wdog: memory-wait watchdog counter.
//   clk     in   clock, rising edge
//   reset   in   asynchronous, active-high
//   clr     in   clear the count (ack seen, state change, or not waiting)
//   inc     in   one more cycle waited without an ack
//   timeout out  this is the (2**WDOG_W-1)-th consecutive un-acked wait cycle
module multi_wdog #(
   parameter int unsigned WDOG_W = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic timeout
);

   // The count holds the number of earlier un-acked cycles, so the cycle that sees
   // 2**WDOG_W-2 here is the last allowed one.
   localparam logic [WDOG_W-1:0] LAST = WDOG_W'((2 ** WDOG_W) - 2);

   logic [WDOG_W-1:0] cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (inc) begin
         cnt_q <= cnt_q + WDOG_W'(1);
      end
   end

   assign timeout = inc && (cnt_q == LAST);

endmodule

// File: rtl/multi_ctrl_fsm.sv
// multi_ctrl_fsm: main control FSM of the multi-cycle MIPS core.
//   clk, reset                 clock; asynchronous active-high reset
//   op_code, alu_zero, mem_ack IR[31:26], ALU zero flag, memory handshake
//   pc_wr, pc_src, iord        PC load/source, memory address source
//   mem_rd, mem_wr, ir_wr      memory requests, IR load
//   alu_op, alu_src_a/b        ALU control and operand selects
//   reg_dst, mem_to_reg, reg_wr register file write controls
//   state                      debug view of the current state
//   illegal_op, wdog_err       sticky trap causes
//   instr_cnt                  retired-instruction counter (wraps)
// Optional JAL support is compiled in when MULTI_JAL_EN is defined.
module multi_ctrl_fsm
   import multi_pkg::*;
#(
   parameter int unsigned WDOG_W = 4,
   parameter int unsigned CNT_W  = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       op_code,
   input  logic             alu_zero,
   input  logic             mem_ack,
   output logic             pc_wr,
   output logic [1:0]       pc_src,
   output logic             iord,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic             ir_wr,
   output logic [1:0]       alu_op,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       reg_dst,
   output logic [1:0]       mem_to_reg,
   output logic             reg_wr,
   output logic [3:0]       state,
   output logic             illegal_op,
   output logic             wdog_err,
   output logic [CNT_W-1:0] instr_cnt
);

   state_e           state_q, state_d;
   logic             illegal_q, wdog_err_q;
   logic [CNT_W-1:0] instr_cnt_q;
   logic             dec_illegal;
   logic             wdog_inc, wdog_clr, wdog_timeout;
   logic             retire;

   // Watchdog: counts un-acked cycles in the memory wait states.
   assign wdog_inc = is_mem_wait(state_q) && !mem_ack;
   assign wdog_clr = !wdog_inc || (state_d != state_q);

   multi_wdog #(
      .WDOG_W (WDOG_W)
   ) u_wdog (
      .clk     (clk),
      .reset   (reset),
      .clr     (wdog_clr),
      .inc     (wdog_inc),
      .timeout (wdog_timeout)
   );

   // Next-state logic; an ack on the timeout cycle takes priority over the trap.
   always_comb begin
      state_d     = state_q;
      dec_illegal = 1'b0;
      unique case (state_q)
         StFetch: begin
            if (mem_ack)           state_d = StDecode;
            else if (wdog_timeout) state_d = StTrap;
         end
         StDecode: begin
            unique case (op_code)
               OP_LW, OP_SW:   state_d = StMemAddr;
               OP_R:           state_d = StRExec;
               OP_BEQ, OP_BNE: state_d = StBranch;
               OP_J:           state_d = StJump;
               OP_ADDI:        state_d = StIExec;
`ifdef MULTI_JAL_EN
               OP_JAL:         state_d = StJal;
`endif
               default: begin
                  state_d     = StTrap;
                  dec_illegal = 1'b1;
               end
            endcase
         end
         StMemAddr:  state_d = (op_code == OP_SW) ? StMemWrite : StMemRead;
         StMemRead: begin
            if (mem_ack)           state_d = StMemWb;
            else if (wdog_timeout) state_d = StTrap;
         end
         StMemWb:    state_d = StFetch;
         StMemWrite: begin
            if (mem_ack)           state_d = StFetch;
            else if (wdog_timeout) state_d = StTrap;
         end
         StRExec:    state_d = StRWb;
         StRWb:      state_d = StFetch;
         StBranch:   state_d = StFetch;
         StJump:     state_d = StFetch;
         StIExec:    state_d = StIWb;
         StIWb:      state_d = StFetch;
         StTrap:     state_d = StTrap;
`ifdef MULTI_JAL_EN
         StJal:      state_d = StFetch;
`endif
         default:    state_d = StTrap;
      endcase
   end

   assign retire = (state_d == StFetch) && (state_q != StFetch);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StFetch;
         illegal_q   <= 1'b0;
         wdog_err_q  <= 1'b0;
         instr_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (dec_illegal)  illegal_q   <= 1'b1;
         if (wdog_timeout) wdog_err_q  <= 1'b1;
         if (retire)       instr_cnt_q <= instr_cnt_q + CNT_W'(1);
      end
   end

   // Moore output decode; only FETCH and BRANCH strobes look at inputs.
   always_comb begin
      pc_wr      = 1'b0;
      pc_src     = PCSRC_ALU;
      iord       = IORD_PC;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      ir_wr      = 1'b0;
      alu_op     = ALU_OP_ADD;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_B;
      reg_dst    = REGDST_RT;
      mem_to_reg = M2R_ALUOUT;
      reg_wr     = 1'b0;
      unique case (state_q)
         StFetch: begin
            mem_rd    = 1'b1;
            alu_src_b = SRCB_FOUR;
            ir_wr     = mem_ack;
            pc_wr     = mem_ack;
         end
         StDecode: alu_src_b = SRCB_IMM_SH2;
         StMemAddr, StIExec: begin
            alu_src_a = SRCA_A;
            alu_src_b = SRCB_IMM;
         end
         StMemRead: begin
            mem_rd = 1'b1;
            iord   = IORD_ALUOUT;
         end
         StMemWb: begin
            mem_to_reg = M2R_MDR;
            reg_wr     = 1'b1;
         end
         StMemWrite: begin
            mem_wr = 1'b1;
            iord   = IORD_ALUOUT;
         end
         StRExec: begin
            alu_src_a = SRCA_A;
            alu_op    = ALU_OP_FUNCT;
         end
         StRWb: begin
            reg_dst = REGDST_RD;
            reg_wr  = 1'b1;
         end
         StBranch: begin
            alu_src_a = SRCA_A;
            alu_op    = ALU_OP_SUB;
            pc_src    = PCSRC_ALUOUT;
            pc_wr     = (op_code == OP_BNE) ? !alu_zero : alu_zero;
         end
         StJump: begin
            pc_src = PCSRC_JUMP;
            pc_wr  = 1'b1;
         end
         StIWb: reg_wr = 1'b1;
`ifdef MULTI_JAL_EN
         // PC already holds PC+4 from FETCH, so it is the link value.
         StJal: begin
            pc_src     = PCSRC_JUMP;
            pc_wr      = 1'b1;
            reg_dst    = REGDST_RA;
            mem_to_reg = M2R_PC;
            reg_wr     = 1'b1;
         end
`endif
         default: ;
      endcase
      // Strobes drop as soon as reset rises, without waiting for a clock.
      if (reset) begin
         pc_wr  = 1'b0;
         ir_wr  = 1'b0;
         mem_rd = 1'b0;
         mem_wr = 1'b0;
         reg_wr = 1'b0;
      end
   end

   assign state      = state_q;
   assign illegal_op = illegal_q;
   assign wdog_err   = wdog_err_q;
   assign instr_cnt  = instr_cnt_q;

endmodule

// File: tb/tb_multi_ctrl_fsm.sv
// tb_multi_ctrl_fsm: directed self-checking bench for multi_ctrl_fsm (WDOG_W=4, CNT_W=32).
// Works with or without MULTI_JAL_EN defined.
module tb_multi_ctrl_fsm;

   logic        clk;
   logic        reset;
   logic [5:0]  op_code;
   logic        alu_zero;
   logic        mem_ack;
   logic        pc_wr, iord, mem_rd, mem_wr, ir_wr, alu_src_a, reg_wr;
   logic [1:0]  pc_src, alu_op, alu_src_b, reg_dst, mem_to_reg;
   logic [3:0]  state;
   logic        illegal_op, wdog_err;
   logic [31:0] instr_cnt;

   int n_checks;
   int n_errors;
   int exp_cnt;

   // {pc_wr, pc_src, iord, mem_rd, mem_wr, ir_wr, alu_op, alu_src_a, alu_src_b,
   //  reg_dst, mem_to_reg, reg_wr}
   logic [16:0] ctl;
   logic [4:0]  strobes;
   assign ctl = {pc_wr, pc_src, iord, mem_rd, mem_wr, ir_wr, alu_op, alu_src_a, alu_src_b,
                 reg_dst, mem_to_reg, reg_wr};
   assign strobes = {pc_wr, ir_wr, mem_rd, mem_wr, reg_wr};

   localparam logic [16:0] E_FETCH_ACK  = {1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0,
                                           2'b01, 2'b00, 2'b00, 1'b0};
   localparam logic [16:0] E_FETCH_WAIT = {1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0,
                                           2'b01, 2'b00, 2'b00, 1'b0};
   localparam logic [16:0] E_DECODE     = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0,
                                           2'b11, 2'b00, 2'b00, 1'b0};
   localparam logic [16:0] E_MEM_ADDR   = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1,
                                           2'b10, 2'b00, 2'b00, 1'b0};
   localparam logic [16:0] E_MEM_READ   = {1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0,
                                           2'b00, 2'b00, 2'b00, 1'b0};
   localparam logic [16:0] E_MEM_WB     = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0,
                                           2'b00, 2'b00, 2'b01, 1'b1};
   localparam logic [16:0] E_MEM_WRITE  = {1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0,
                                           2'b00, 2'b00, 2'b00, 1'b0};
   localparam logic [16:0] E_R_EXEC     = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1,
                                           2'b00, 2'b00, 2'b00, 1'b0};
   localparam logic [16:0] E_R_WB       = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0,
                                           2'b00, 2'b01, 2'b00, 1'b1};
   localparam logic [16:0] E_BR_TAKEN   = {1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1,
                                           2'b00, 2'b00, 2'b00, 1'b0};
   localparam logic [16:0] E_BR_NOT     = {1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1,
                                           2'b00, 2'b00, 2'b00, 1'b0};
   localparam logic [16:0] E_JUMP       = {1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0,
                                           2'b00, 2'b00, 2'b00, 1'b0};
   localparam logic [16:0] E_I_WB       = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0,
                                           2'b00, 2'b00, 2'b00, 1'b1};
   localparam logic [16:0] E_JAL        = {1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0,
                                           2'b00, 2'b10, 2'b10, 1'b1};

   multi_ctrl_fsm #(
      .WDOG_W (4),
      .CNT_W  (32)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .op_code    (op_code),
      .alu_zero   (alu_zero),
      .mem_ack    (mem_ack),
      .pc_wr      (pc_wr),
      .pc_src     (pc_src),
      .iord       (iord),
      .mem_rd     (mem_rd),
      .mem_wr     (mem_wr),
      .ir_wr      (ir_wr),
      .alu_op     (alu_op),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .reg_wr     (reg_wr),
      .state      (state),
      .illegal_op (illegal_op),
      .wdog_err   (wdog_err),
      .instr_cnt  (instr_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Asserts reset mid-cycle and releases it 1 ns after the next rising edge.
   task automatic do_reset();
      reset = 1'b1;
      #1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_cnt = 0;
   endtask

   task automatic test_reset();
      reset = 1'b0; mem_ack = 1'b1; op_code = 6'h00; alu_zero = 1'b0;
      #2;
      reset = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_checks++;
      if (state !== 4'd0 || strobes !== 5'b0 || instr_cnt !== 32'd0 ||
          illegal_op !== 1'b0 || wdog_err !== 1'b0) begin
         $display("FAIL reset_hold: state=%0d strobes=%b cnt=%0d ill=%b wd=%b, want 0/00000/0/0/0",
                  state, strobes, instr_cnt, illegal_op, wdog_err);
         n_errors++;
      end
      reset = 1'b0; mem_ack = 1'b0; exp_cnt = 0;
      #1;
      n_checks++;
      if (state !== 4'd0 || ctl !== E_FETCH_WAIT) begin
         $display("FAIL reset_release: state=%0d ctl=%b, want 0 %b", state, ctl, E_FETCH_WAIT);
         n_errors++;
      end
   endtask

   task automatic test_lw();
      logic [3:0]  st [5];
      logic [16:0] ex [5];
      st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      ex = '{E_FETCH_ACK, E_DECODE, E_MEM_ADDR, E_MEM_READ, E_MEM_WB};
      op_code = 6'h23;
      for (int i = 0; i < 5; i++) begin
         mem_ack = 1'b1; #1;
         n_checks++;
         if (state !== st[i] || ctl !== ex[i]) begin
            $display("FAIL lw step %0d: state=%0d ctl=%b, want %0d %b", i, state, ctl, st[i], ex[i]);
            n_errors++;
         end
         @(posedge clk); #1;
      end
      mem_ack = 1'b0; exp_cnt++; #1;
      n_checks++;
      if (state !== 4'd0 || instr_cnt !== 32'(exp_cnt)) begin
         $display("FAIL lw_retire: state=%0d cnt=%0d, want 0 %0d", state, instr_cnt, exp_cnt);
         n_errors++;
      end
   endtask

   // FETCH acked on its 4th cycle, then an R-type instruction.
   task automatic test_fetch_wait();
      logic        ak [7];
      logic [3:0]  st [7];
      logic [16:0] ex [7];
      ak = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      st = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd6, 4'd7};
      ex = '{E_FETCH_WAIT, E_FETCH_WAIT, E_FETCH_WAIT, E_FETCH_ACK, E_DECODE, E_R_EXEC, E_R_WB};
      op_code = 6'h00;
      for (int i = 0; i < 7; i++) begin
         mem_ack = ak[i]; #1;
         n_checks++;
         if (state !== st[i] || ctl !== ex[i]) begin
            $display("FAIL fetch_wait step %0d: state=%0d ctl=%b, want %0d %b",
                     i, state, ctl, st[i], ex[i]);
            n_errors++;
         end
         @(posedge clk); #1;
      end
      mem_ack = 1'b0; exp_cnt++; #1;
      n_checks++;
      if (state !== 4'd0 || instr_cnt !== 32'(exp_cnt)) begin
         $display("FAIL r_retire: state=%0d cnt=%0d, want 0 %0d", state, instr_cnt, exp_cnt);
         n_errors++;
      end
   endtask

   // SW whose write is acked on the 3rd MEM_WRITE cycle.
   task automatic test_sw();
      logic        ak [6];
      logic [3:0]  st [6];
      logic [16:0] ex [6];
      ak = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      st = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5};
      ex = '{E_FETCH_ACK, E_DECODE, E_MEM_ADDR, E_MEM_WRITE, E_MEM_WRITE, E_MEM_WRITE};
      op_code = 6'h2B;
      for (int i = 0; i < 6; i++) begin
         mem_ack = ak[i]; #1;
         n_checks++;
         if (state !== st[i] || ctl !== ex[i]) begin
            $display("FAIL sw step %0d: state=%0d ctl=%b, want %0d %b", i, state, ctl, st[i], ex[i]);
            n_errors++;
         end
         @(posedge clk); #1;
      end
      mem_ack = 1'b0; exp_cnt++; #1;
      n_checks++;
      if (state !== 4'd0 || instr_cnt !== 32'(exp_cnt)) begin
         $display("FAIL sw_retire: state=%0d cnt=%0d, want 0 %0d", state, instr_cnt, exp_cnt);
         n_errors++;
      end
   endtask

   task automatic test_branch();
      logic [5:0]  ops [4];
      logic        zs  [4];
      logic [16:0] exb [4];
      ops = '{6'h05, 6'h05, 6'h04, 6'h04};
      zs  = '{1'b0, 1'b1, 1'b1, 1'b0};
      exb = '{E_BR_TAKEN, E_BR_NOT, E_BR_TAKEN, E_BR_NOT};
      for (int r = 0; r < 4; r++) begin
         op_code = ops[r]; alu_zero = zs[r]; mem_ack = 1'b1;
         @(posedge clk); #1;   // FETCH -> DECODE
         @(posedge clk); #1;   // DECODE -> BRANCH
         #1;
         n_checks++;
         if (state !== 4'd8 || ctl !== exb[r]) begin
            $display("FAIL branch op=%h z=%b: state=%0d ctl=%b, want 8 %b",
                     ops[r], zs[r], state, ctl, exb[r]);
            n_errors++;
         end
         @(posedge clk); #1;
         mem_ack = 1'b0; exp_cnt++; #1;
         n_checks++;
         if (state !== 4'd0 || instr_cnt !== 32'(exp_cnt)) begin
            $display("FAIL branch_return op=%h: state=%0d cnt=%0d, want 0 %0d",
                     ops[r], state, instr_cnt, exp_cnt);
            n_errors++;
         end
      end
      alu_zero = 1'b0;
   endtask

   // J followed by ADDI.
   task automatic test_jump_addi();
      logic [5:0]  ops [7];
      logic [3:0]  st  [7];
      logic [16:0] ex  [7];
      ops = '{6'h02, 6'h02, 6'h02, 6'h08, 6'h08, 6'h08, 6'h08};
      st  = '{4'd0, 4'd1, 4'd9, 4'd0, 4'd1, 4'd10, 4'd11};
      ex  = '{E_FETCH_ACK, E_DECODE, E_JUMP, E_FETCH_ACK, E_DECODE, E_MEM_ADDR, E_I_WB};
      for (int i = 0; i < 7; i++) begin
         op_code = ops[i]; mem_ack = 1'b1; #1;
         n_checks++;
         if (state !== st[i] || ctl !== ex[i]) begin
            $display("FAIL jump_addi step %0d: state=%0d ctl=%b, want %0d %b",
                     i, state, ctl, st[i], ex[i]);
            n_errors++;
         end
         @(posedge clk); #1;
      end
      mem_ack = 1'b0; exp_cnt += 2; #1;
      n_checks++;
      if (state !== 4'd0 || instr_cnt !== 32'(exp_cnt)) begin
         $display("FAIL jump_addi_retire: state=%0d cnt=%0d, want 0 %0d", state, instr_cnt, exp_cnt);
         n_errors++;
      end
   endtask

   task automatic test_illegal();
      int cnt_before;
      cnt_before = exp_cnt;
      op_code = 6'h3F; mem_ack = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      for (int i = 0; i < 20; i++) begin
         mem_ack = i[0]; alu_zero = i[1]; #1;
         n_checks++;
         if (state !== 4'd12 || ctl !== 17'd0 || illegal_op !== 1'b1 || wdog_err !== 1'b0 ||
             instr_cnt !== 32'(cnt_before)) begin
            $display("FAIL illegal_trap cyc %0d: state=%0d ctl=%b ill=%b wd=%b cnt=%0d, want 12 0 1 0 %0d",
                     i, state, ctl, illegal_op, wdog_err, instr_cnt, cnt_before);
            n_errors++;
         end
         @(posedge clk); #1;
      end
      mem_ack = 1'b1; alu_zero = 1'b0;
      reset = 1'b1; #1;
      n_checks++;
      if (state !== 4'd0 || illegal_op !== 1'b0 || instr_cnt !== 32'd0 || strobes !== 5'b0) begin
         $display("FAIL illegal_reset: state=%0d ill=%b cnt=%0d strobes=%b, want 0 0 0 00000",
                  state, illegal_op, instr_cnt, strobes);
         n_errors++;
      end
      @(posedge clk); #1;
      reset = 1'b0; mem_ack = 1'b0; exp_cnt = 0;
   endtask

   task automatic test_watchdog();
      do_reset();
      mem_ack = 1'b0;
      for (int i = 1; i <= 15; i++) begin
         #1;
         n_checks++;
         if (state !== 4'd0 || mem_rd !== 1'b1 || wdog_err !== 1'b0) begin
            $display("FAIL wdog_fetch_wait cyc %0d: state=%0d mem_rd=%b wd=%b, want 0 1 0",
                     i, state, mem_rd, wdog_err);
            n_errors++;
         end
         @(posedge clk); #1;
      end
      #1;
      n_checks++;
      if (state !== 4'd12 || wdog_err !== 1'b1 || illegal_op !== 1'b0 || ctl !== 17'd0) begin
         $display("FAIL wdog_fetch_trap: state=%0d wd=%b ill=%b ctl=%b, want 12 1 0 0",
                  state, wdog_err, illegal_op, ctl);
         n_errors++;
      end
      // Ack on the 15th wait cycle must win over the timeout.
      do_reset();
      op_code = 6'h23;
      for (int i = 1; i <= 15; i++) begin
         mem_ack = (i == 15);
         @(posedge clk); #1;
      end
      mem_ack = 1'b0; #1;
      n_checks++;
      if (state !== 4'd1 || wdog_err !== 1'b0) begin
         $display("FAIL wdog_ack_on_last: state=%0d wd=%b, want 1 0", state, wdog_err);
         n_errors++;
      end
      @(posedge clk); #1;   // DECODE -> MEM_ADDR
      @(posedge clk); #1;   // MEM_ADDR -> MEM_READ
      for (int i = 1; i <= 15; i++) begin
         #1;
         n_checks++;
         if (state !== 4'd3 || ctl !== E_MEM_READ) begin
            $display("FAIL wdog_read_wait cyc %0d: state=%0d ctl=%b, want 3 %b",
                     i, state, ctl, E_MEM_READ);
            n_errors++;
         end
         @(posedge clk); #1;
      end
      #1;
      n_checks++;
      if (state !== 4'd12 || wdog_err !== 1'b1) begin
         $display("FAIL wdog_read_trap: state=%0d wd=%b, want 12 1", state, wdog_err);
         n_errors++;
      end
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      op_code = 6'h23; mem_ack = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      @(posedge clk); #1;
      #1;
      n_checks++;
      if (state !== 4'd3 || mem_rd !== 1'b1) begin
         $display("FAIL mid_wait_pre: state=%0d mem_rd=%b, want 3 1", state, mem_rd);
         n_errors++;
      end
      reset = 1'b1; #1;
      n_checks++;
      if (state !== 4'd0 || mem_rd !== 1'b0 || strobes !== 5'b0) begin
         $display("FAIL mid_wait_reset: state=%0d mem_rd=%b strobes=%b, want 0 0 00000",
                  state, mem_rd, strobes);
         n_errors++;
      end
      @(posedge clk); #1;
      reset = 1'b0; exp_cnt = 0; #1;
      n_checks++;
      if (state !== 4'd0 || ctl !== E_FETCH_WAIT) begin
         $display("FAIL mid_wait_refetch: state=%0d ctl=%b, want 0 %b", state, ctl, E_FETCH_WAIT);
         n_errors++;
      end
   endtask

   task automatic test_jal();
      op_code = 6'h03; mem_ack = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      mem_ack = 1'b0; #1;
`ifdef MULTI_JAL_EN
      n_checks++;
      if (state !== 4'd13 || ctl !== E_JAL) begin
         $display("FAIL jal_exec: state=%0d ctl=%b, want 13 %b", state, ctl, E_JAL);
         n_errors++;
      end
      @(posedge clk); #1;
      exp_cnt++;
      n_checks++;
      if (state !== 4'd0 || instr_cnt !== 32'(exp_cnt)) begin
         $display("FAIL jal_retire: state=%0d cnt=%0d, want 0 %0d", state, instr_cnt, exp_cnt);
         n_errors++;
      end
`else
      n_checks++;
      if (state !== 4'd12 || illegal_op !== 1'b1 || ctl !== 17'd0) begin
         $display("FAIL jal_disabled: state=%0d ill=%b ctl=%b, want 12 1 0", state, illegal_op, ctl);
         n_errors++;
      end
`endif
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      exp_cnt  = 0;
      test_reset();
      test_lw();
      test_fetch_wait();
      test_sw();
      test_branch();
      test_jump_addi();
      test_illegal();
      test_watchdog();
      test_reset_mid_wait();
      test_jal();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
